// File: rtl/bridge_mcu_regs.sv
// MCU-side byte register file feeding the CW305-to-X-HEEP OBI bridge.
// Assembles instruction/address words and captures returned OBI read data.
module bridge_mcu_regs #(
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [7:0]        mcu_wdata,
    input  logic              mcu_wr,
    input  logic              mcu_rd,
    output logic [7:0]        mcu_rdata,
    output logic              instr_valid,
    output logic              addr_valid,
    input  logic              rst_instr_valid,
    input  logic              rst_new_address_valid,
    output logic [31:0]       instruction,
    output logic [31:0]       new_section_address,
    input  logic              busy,
    input  logic              OBI_rvalid,
    input  logic [31:0]       OBI_rdata
);

    localparam int CNT_BYTES = (COUNT_W + 7) / 8;

    logic [31:0]        instr_q;
    logic [31:0]        addr_q;
    logic [31:0]        rdata_q;
    logic [COUNT_W-1:0] count_q;
    logic               rdata_valid;
    logic               overrun;
    logic               rdata_lost;

    logic [1:0]  byte_sel;
    logic        instr_hit;
    logic        addr_hit;
    logic        stat_hit;
    logic        rdat_hit;
    logic        cnt_hit;
    logic        rd_en;
    logic        rd_last;
    logic        stat_wr;
    logic        blocked;
    logic [7:0]  status;
    logic [31:0] cnt_ext;
    logic [7:0]  rd_byte;

    assign byte_sel  = mcu_addr[1:0];
    assign instr_hit = mcu_addr[ADDR_W-1:2] == (ADDR_W-2)'(0);
    assign addr_hit  = mcu_addr[ADDR_W-1:2] == (ADDR_W-2)'(1);
    assign stat_hit  = mcu_addr == ADDR_W'(8);
    assign rdat_hit  = mcu_addr[ADDR_W-1:2] == (ADDR_W-2)'(3);
    assign cnt_hit   = (mcu_addr >= ADDR_W'(16)) &&
                       (mcu_addr < ADDR_W'(16 + CNT_BYTES));

    // A simultaneous write wins; the read then returns zero.
    assign rd_en   = mcu_rd && !mcu_wr;
    assign rd_last = rd_en && rdat_hit && (byte_sel == 2'd3);
    assign stat_wr = mcu_wr && stat_hit;
    assign blocked = mcu_wr && ((instr_hit && instr_valid) ||
                                (addr_hit && addr_valid));

    assign status  = {2'b00, rdata_lost, overrun, rdata_valid,
                      busy, addr_valid, instr_valid};
    assign cnt_ext = 32'(count_q);

    assign instruction         = instr_q;
    assign new_section_address = addr_q;

    always_comb begin
        rd_byte = 8'h00;
        unique case (1'b1)
            instr_hit: rd_byte = instr_q[8*byte_sel +: 8];
            addr_hit:  rd_byte = addr_q[8*byte_sel +: 8];
            stat_hit:  rd_byte = status;
            rdat_hit:  rd_byte = rdata_q[8*byte_sel +: 8];
            cnt_hit:   rd_byte = cnt_ext[8*byte_sel +: 8];
            default:   rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcu_rdata   <= 8'h00;
            instr_q     <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            count_q     <= '0;
            instr_valid <= 1'b0;
            addr_valid  <= 1'b0;
            rdata_valid <= 1'b0;
            overrun     <= 1'b0;
            rdata_lost  <= 1'b0;
        end else begin
            if (rd_en) begin
                mcu_rdata <= rd_byte;
            end else if (mcu_rd) begin
                mcu_rdata <= 8'h00;
            end

            if (rst_instr_valid && instr_valid) begin
                instr_valid <= 1'b0;
                count_q     <= count_q + COUNT_W'(1);
            end
            if (mcu_wr && instr_hit && !instr_valid) begin
                instr_q[8*byte_sel +: 8] <= mcu_wdata;
                if (byte_sel == 2'd3) instr_valid <= 1'b1;
            end

            if (rst_new_address_valid && addr_valid) begin
                addr_valid <= 1'b0;
            end
            if (mcu_wr && addr_hit && !addr_valid) begin
                addr_q[8*byte_sel +: 8] <= mcu_wdata;
                if (byte_sel == 2'd3) addr_valid <= 1'b1;
            end

            if (mcu_wr && mcu_addr == ADDR_W'(16)) begin
                count_q <= '0;
            end

            // Set events take priority over a same-cycle W1C.
            if (stat_wr && mcu_wdata[4]) overrun <= 1'b0;
            if (blocked) overrun <= 1'b1;

            if (stat_wr && mcu_wdata[5]) rdata_lost <= 1'b0;
            if (rd_last) rdata_valid <= 1'b0;
            if (OBI_rvalid) begin
                rdata_q     <= OBI_rdata;
                rdata_valid <= 1'b1;
                if (rdata_valid && !rd_last) rdata_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bridge_mcu_regs.sv
// Bench for bridge_mcu_regs: directed plan with literal checks plus
// randomized traffic compared against a byte-level register model.
module tb_bridge_mcu_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mcu_addr = '0;
    logic [7:0]  mcu_wdata = '0;
    logic        mcu_wr = 1'b0;
    logic        mcu_rd = 1'b0;
    logic [7:0]  mcu_rdata;
    logic        instr_valid;
    logic        addr_valid;
    logic        rst_instr_valid = 1'b0;
    logic        rst_new_address_valid = 1'b0;
    logic [31:0] instruction;
    logic [31:0] new_section_address;
    logic        busy = 1'b0;
    logic        OBI_rvalid = 1'b0;
    logic [31:0] OBI_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bridge_mcu_regs #(.ADDR_W(8), .COUNT_W(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mcu_addr              (mcu_addr),
        .mcu_wdata             (mcu_wdata),
        .mcu_wr                (mcu_wr),
        .mcu_rd                (mcu_rd),
        .mcu_rdata             (mcu_rdata),
        .instr_valid           (instr_valid),
        .addr_valid            (addr_valid),
        .rst_instr_valid       (rst_instr_valid),
        .rst_new_address_valid (rst_new_address_valid),
        .instruction           (instruction),
        .new_section_address   (new_section_address),
        .busy                  (busy),
        .OBI_rvalid            (OBI_rvalid),
        .OBI_rdata             (OBI_rdata)
    );

    // Reference model: registers held as byte arrays
    logic [7:0]  m_instr [4];
    logic [7:0]  m_addr  [4];
    logic [7:0]  m_rdat  [4];
    logic        m_iv, m_av, m_rv, m_ov, m_lost;
    logic [31:0] m_cnt;
    logic [7:0]  m_rd;

    function automatic logic [31:0] word_of(input logic [7:0] b [4]);
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a < 8'd4)  return m_instr[a[1:0]];
        if (a < 8'd8)  return m_addr[a[1:0]];
        if (a == 8'd8) return {2'b00, m_lost, m_ov, m_rv, busy, m_av, m_iv};
        if (a >= 8'd12 && a < 8'd16) return m_rdat[a[1:0]];
        if (a >= 8'd16 && a < 8'd20) return m_cnt[8*int'(a[1:0]) +: 8];
        return 8'h00;
    endfunction

    task automatic model_update();
        logic n_iv, n_av, n_rv, n_ov, n_lost, rd0f;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_instr[i] = '0; m_addr[i] = '0; m_rdat[i] = '0;
            end
            {m_iv, m_av, m_rv, m_ov, m_lost} = '0;
            m_cnt = '0;
            m_rd = '0;
            return;
        end
        if (mcu_rd) m_rd = mcu_wr ? 8'h00 : m_read(mcu_addr);
        n_iv = m_iv; n_av = m_av; n_rv = m_rv; n_ov = m_ov; n_lost = m_lost;
        if (mcu_wr && mcu_addr == 8'd8) begin
            if (mcu_wdata[4]) n_ov = 1'b0;
            if (mcu_wdata[5]) n_lost = 1'b0;
        end
        if (rst_instr_valid && m_iv) begin
            n_iv = 1'b0;
            m_cnt = m_cnt + 1;
        end
        if (rst_new_address_valid && m_av) n_av = 1'b0;
        if (mcu_wr && mcu_addr < 8'd4) begin
            if (m_iv) n_ov = 1'b1;
            else begin
                m_instr[mcu_addr[1:0]] = mcu_wdata;
                if (mcu_addr == 8'd3) n_iv = 1'b1;
            end
        end
        if (mcu_wr && mcu_addr >= 8'd4 && mcu_addr < 8'd8) begin
            if (m_av) n_ov = 1'b1;
            else begin
                m_addr[mcu_addr[1:0]] = mcu_wdata;
                if (mcu_addr == 8'd7) n_av = 1'b1;
            end
        end
        if (mcu_wr && mcu_addr == 8'd16) m_cnt = '0;
        rd0f = mcu_rd && !mcu_wr && mcu_addr == 8'd15;
        if (rd0f) n_rv = 1'b0;
        if (OBI_rvalid) begin
            for (int i = 0; i < 4; i++) m_rdat[i] = OBI_rdata[8*i +: 8];
            if (m_rv && !rd0f) n_lost = 1'b1;
            n_rv = 1'b1;
        end
        {m_iv, m_av, m_rv, m_ov, m_lost} = {n_iv, n_av, n_rv, n_ov, n_lost};
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("instr_valid", 32'(instr_valid), 32'(m_iv));
        chk("addr_valid", 32'(addr_valid), 32'(m_av));
        chk("instruction", instruction, word_of(m_instr));
        chk("new_section_address", new_section_address, word_of(m_addr));
        chk("mcu_rdata", 32'(mcu_rdata), 32'(m_rd));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
        mcu_wr = 1'b0;
        mcu_rd = 1'b0;
        rst_instr_valid = 1'b0;
        rst_new_address_valid = 1'b0;
        OBI_rvalid = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        mcu_addr = a; mcu_wdata = d; mcu_wr = 1'b1;
        step();
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
        mcu_addr = a; mcu_rd = 1'b1;
        step();
        d = mcu_rdata;
    endtask

    task automatic pulse_instr();
        rst_instr_valid = 1'b1;
        step();
    endtask

    logic [7:0] rb;
    logic [7:0] bytes [4];
    int r;

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk("rst_instr_valid_out", 32'(instr_valid), 32'h0);
        chk("rst_rdata", 32'(mcu_rdata), 32'h0);
        rst_n = 1'b1;

        bytes = '{8'h13, 8'h05, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) wr_reg(8'(i), bytes[i]);
        chk("iv_before_b3", 32'(instr_valid), 32'h0);
        wr_reg(8'd3, bytes[3]);
        chk("iv_after_b3", 32'(instr_valid), 32'h1);
        chk("instr_word", instruction, 32'h0000_0513);
        rd_reg(8'd8, rb);
        chk("status_iv", 32'(rb), 32'h01);

        bytes = '{8'h00, 8'h00, 8'h00, 8'h80};
        for (int i = 0; i < 4; i++) wr_reg(8'(4 + i), bytes[i]);
        chk("sect_addr", new_section_address, 32'h8000_0000);
        chk("av_set", 32'(addr_valid), 32'h1);
        rst_new_address_valid = 1'b1;
        step();
        chk("av_clr", 32'(addr_valid), 32'h0);
        rd_reg(8'd8, rb);
        chk("status_av_clr", 32'(rb), 32'h01);

        wr_reg(8'd0, 8'hFF);
        chk("instr_blocked", instruction, 32'h0000_0513);
        rd_reg(8'd8, rb);
        chk("status_overrun", 32'(rb), 32'h11);
        wr_reg(8'd8, 8'h10);
        rd_reg(8'd8, rb);
        chk("status_w1c", 32'(rb), 32'h01);

        OBI_rvalid = 1'b1; OBI_rdata = 32'hDEAD_BEEF;
        step();
        rd_reg(8'd8, rb);
        chk("status_rv", 32'(rb), 32'h09);
        bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++) begin
            rd_reg(8'(12 + i), rb);
            chk("rdata_byte", 32'(rb), 32'(bytes[i]));
        end
        rd_reg(8'd8, rb);
        chk("status_rv_clr", 32'(rb), 32'h01);
        OBI_rvalid = 1'b1; OBI_rdata = 32'h1111_1111;
        step();
        OBI_rvalid = 1'b1; OBI_rdata = 32'h2222_2222;
        step();
        rd_reg(8'd8, rb);
        chk("status_lost", 32'(rb), 32'h29);
        rd_reg(8'd12, rb);
        chk("rdata_second", 32'(rb), 32'h22);
        wr_reg(8'd8, 8'h20);
        rd_reg(8'd15, rb);
        rd_reg(8'd8, rb);
        chk("status_lost_clr", 32'(rb), 32'h01);

        pulse_instr();
        for (int i = 0; i < 2; i++) begin
            wr_reg(8'd3, 8'h00);
            pulse_instr();
        end
        pulse_instr();
        rd_reg(8'd16, rb);
        chk("count3", 32'(rb), 32'h03);
        rd_reg(8'd17, rb);
        chk("count3_hi", 32'(rb), 32'h00);
        wr_reg(8'd16, 8'h5A);
        rd_reg(8'd16, rb);
        chk("count_clr", 32'(rb), 32'h00);

        busy = 1'b1;
        wr_reg(8'd3, 8'h12);
        chk("commit_again", 32'(instr_valid), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_iv", 32'(instr_valid), 32'h0);
        chk("mid_rst_instr", instruction, 32'h0);
        rd_reg(8'd8, rb);
        chk("mid_rst_status", 32'(rb), 32'h04);

        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            mcu_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                   : 8'($urandom_range(0, 20));
            mcu_wdata = 8'($urandom);
            r = $urandom_range(0, 15);
            mcu_wr = (r < 5) || (r == 15);
            mcu_rd = (r >= 5 && r < 11) || (r == 15);
            rst_instr_valid = ($urandom_range(0, 4) == 0);
            rst_new_address_valid = ($urandom_range(0, 4) == 0);
            OBI_rvalid = ($urandom_range(0, 5) == 0);
            OBI_rdata = $urandom;
            busy = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bridge_mcu_regs.md
Name: bridge_mcu_regs

Overview:
- MCU-side register file that sits directly upstream of the CW305-to-X-HEEP OBI bridge.
- Accepts byte-wide register accesses from the CW305 USB/MCU interface and assembles the 32-bit instruction and section-address words.
- Drives the instr_valid/addr_valid handshake flags into the bridge and clears them on the bridge's reset pulses.
- Captures OBI read data returned through the bridge and exposes it, together with status and error flags, to the MCU.

Parameters:
- ADDR_W, 8, width of the MCU register address bus.
- COUNT_W, 32, width of the completed-instruction counter; must be 32 or less.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- mcu_addr  in  ADDR_W  byte address of the register access.
- mcu_wdata  in  8  write byte.
- mcu_wr  in  1  write strobe, one cycle per byte.
- mcu_rd  in  1  read strobe, one cycle per byte.
- mcu_rdata  out  8  read byte, registered.
- instr_valid  out  1  instruction word committed and pending at the bridge.
- addr_valid  out  1  section address committed and pending at the bridge.
- rst_instr_valid  in  1  one-cycle pulse from the bridge: instruction consumed.
- rst_new_address_valid  in  1  one-cycle pulse from the bridge: address consumed.
- instruction  out  32  assembled instruction word to the bridge.
- new_section_address  out  32  assembled section address to the bridge.
- busy  in  1  bridge busy flag.
- OBI_rvalid  in  1  OBI read data valid.
- OBI_rdata  in  32  OBI read data.

Behaviour:
- Reset: all outputs, all registers, all flags and the counter are 0. Reset mid-transfer discards partially written words.
- Register map (byte addresses, little-endian):
  - 0x00-0x03 INSTR, R/W.
  - 0x04-0x07 ADDR, R/W.
  - 0x08 STATUS: bit0 instr_valid, bit1 addr_valid, bit2 busy (live), bit3 rdata_valid, bit4 overrun, bit5 rdata_lost, bits 7:6 = 0.
  - 0x0C-0x0F RDATA, read-only.
  - 0x10 up to 0x10+COUNT_W/8-1 INSTR_COUNT, read-only; a write of any value to 0x10 clears it.
  - All other addresses read 0x00; writes to them are ignored.
- INSTR write, when instr_valid=0: updates the addressed byte. A write to byte 0x03 additionally sets instr_valid on the next edge; bytes 0-2 never set it.
- INSTR write, when instr_valid=1: the byte is not updated and overrun is set. The word presented to the bridge therefore stays stable while pending.
- ADDR writes follow the same rules: addr_valid is set by a write to 0x07, and a write while addr_valid=1 is blocked and sets overrun.
- rst_instr_valid clears instr_valid on the next edge and increments INSTR_COUNT, which wraps modulo 2^COUNT_W. rst_new_address_valid clears addr_valid.
- Blocking is decided on the pre-edge flag value. A clear pulse and a blocked write in the same cycle give: flag cleared, byte unchanged, overrun set.
- A pulse arriving while its flag is already 0 is ignored and does not increment the counter.
- OBI_rvalid=1 captures OBI_rdata into RDATA and sets rdata_valid. If rdata_valid was already 1 and no 0x0F read occurs in the same cycle, rdata_lost is also set.
- A read of 0x0F clears rdata_valid. If OBI_rvalid=1 in that same cycle: the read returns the old byte, the new data is captured, rdata_valid stays 1, and rdata_lost is not set.
- Writing 1 to STATUS bit4 or bit5 clears that flag (W1C). A W1C in the same cycle as a set event leaves the flag set.
- Read latency: mcu_rdata is valid on the cycle after mcu_rd and holds until the next read. mcu_wr and mcu_rd are never asserted together; if they are, the write takes effect and the read returns 0x00.
- The instruction and new_section_address outputs are driven directly from their registers.

Test Plan:
- After reset, write 0x13,0x05,0x00,0x00 to 0x00-0x03 -> instr_valid rises exactly one cycle after the 0x03 write. instruction=0x00000513. Reading 0x08 returns 0x01.
- Write 0x00,0x00,0x00,0x80 to 0x04-0x07 -> new_section_address=0x80000000, addr_valid=1. Pulse rst_new_address_valid -> addr_valid=0 and STATUS bit1=0.
- With instr_valid=1, write 0xFF to 0x00 -> instruction unchanged and STATUS=0x11. Write 0x10 to 0x08 -> STATUS=0x01.
- OBI_rvalid with rdata 0xDEADBEEF -> bytes 0x0C..0x0F read EF,BE,AD,DE and rdata_valid clears after the 0x0F read. Two rvalids with no read in between -> STATUS bit5=1 and RDATA holds the second value.
- Issue three commit/rst_instr_valid cycles, plus one spurious rst_instr_valid while instr_valid=0 -> INSTR_COUNT reads 3. Write 0x10 -> reads 0.
- Commit an instruction, then assert rst_n=0 for one cycle -> instr_valid=0, instruction=0, and all STATUS bits 0 except live busy.
